// File: rtl/hyperbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hyperbus_pkg : shared widths, defaults and one-hot state encoding    |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package hyperbus_pkg;

  localparam int HB_WORD_WIDTH          = 16;
  localparam int HB_MASK_WIDTH          = 2;
  localparam int DEFAULT_GAP_CYCLES     = 6;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_WRITE = 5'b00010,
    S_READ  = 5'b00100,
    S_DONE  = 5'b01000,
    S_GAP   = 5'b10000
  } hb_state_t;

endpackage
`default_nettype wire

// File: rtl/hyperbus_lane_swap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hyperbus_lane_swap : 32-bit LE word <-> two big-endian 16-bit beats  |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module hyperbus_lane_swap
  import hyperbus_pkg::*;
(
  input  logic [31:0]              i_wdata,
  input  logic [3:0]               i_sel,
  input  logic [HB_WORD_WIDTH-1:0] i_rbeat0,
  input  logic [HB_WORD_WIDTH-1:0] i_rbeat1,
  output logic [HB_WORD_WIDTH-1:0] o_wbeat0,
  output logic [HB_WORD_WIDTH-1:0] o_wbeat1,
  output logic [HB_MASK_WIDTH-1:0] o_mask0,
  output logic [HB_MASK_WIDTH-1:0] o_mask1,
  output logic [31:0]              o_rdata
);

  // Lower Wishbone byte goes to the upper half of each HyperBus word.
  assign o_wbeat0 = {i_wdata[7:0],   i_wdata[15:8]};
  assign o_wbeat1 = {i_wdata[23:16], i_wdata[31:24]};
  assign o_mask0  = ~{i_sel[0], i_sel[1]};
  assign o_mask1  = ~{i_sel[2], i_sel[3]};
  assign o_rdata  = {i_rbeat1[7:0], i_rbeat1[15:8], i_rbeat0[7:0], i_rbeat0[15:8]};

endmodule
`default_nettype wire

// File: rtl/hyperbus_wb_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hyperbus_wb_bridge : Wishbone B4 classic slave -> 2-beat HyperBus    |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module hyperbus_wb_bridge
  import hyperbus_pkg::*;
#(
  parameter int WB_ADR_WIDTH   = 32,
  parameter int ADDR_LENGTH    = 32,
  parameter int REG_SPACE_BIT  = 31,
  parameter int GAP_CYCLES     = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [WB_ADR_WIDTH-1:0]  wb_adr_i,
  input  logic [31:0]              wb_dat_i,
  input  logic [3:0]               wb_sel_i,
  input  logic                     wb_we_i,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  output logic [31:0]              wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [ADDR_LENGTH-1:0]   hb_adr_o,
  output logic [HB_WORD_WIDTH-1:0] hb_dat_o,
  output logic [HB_MASK_WIDTH-1:0] hb_mask_o,
  output logic                     hb_reg_space_o,
  output logic                     hb_wrq_o,
  output logic                     hb_rrq_o,
  input  logic                     hb_ready_i,
  input  logic                     hb_valid_i,
  input  logic [HB_WORD_WIDTH-1:0] hb_dat_i
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] c_tmo_one  = TMO_W'(1);
  localparam logic [GAP_W-1:0] c_gap_load = GAP_W'(GAP_CYCLES);
  localparam logic [GAP_W-1:0] c_gap_one  = GAP_W'(1);

  hb_state_t                r_state, w_next;
  logic [ADDR_LENGTH-1:0]   r_adr, w_req_adr;
  logic                     r_reg_space, r_wrq, r_rrq, r_live, r_err;
  logic [31:0]              r_wdata, w_rdata;
  logic [3:0]               r_sel;
  logic [1:0]               r_beat;
  logic [TMO_W-1:0]         r_tmo;
  logic [GAP_W-1:0]         r_gap;
  logic [HB_WORD_WIDTH-1:0] r_rbeat0, r_rbeat1, w_wbeat0, w_wbeat1;
  logic [HB_MASK_WIDTH-1:0] w_mask0, w_mask1;
  logic                     w_accept, w_adv, w_timeout, w_busy, w_tmo_hit;
  logic                     w_unused_adr;

  assign w_req_adr    = ADDR_LENGTH'({wb_adr_i[REG_SPACE_BIT-1:2], 1'b0});
  assign w_busy       = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_tmo_hit    = (r_tmo == c_tmo_last);
  assign w_unused_adr = ^wb_adr_i;

  hyperbus_lane_swap u_lane_swap (
    .i_wdata  (r_wdata),
    .i_sel    (r_sel),
    .i_rbeat0 (r_rbeat0),
    .i_rbeat1 (r_rbeat1),
    .o_wbeat0 (w_wbeat0),
    .o_wbeat1 (w_wbeat1),
    .o_mask0  (w_mask0),
    .o_mask1  (w_mask1),
    .o_rdata  (w_rdata)
  );

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_adv     = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (wb_cyc_i && wb_stb_i && (r_gap == '0)) begin
          w_accept = 1'b1;
          w_next   = wb_we_i ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        // Beat counter value 2 holds wrq one extra clock after the last word.
        if (r_beat == 2'd2) begin
          w_next = S_DONE;
        end else if (hb_ready_i) begin
          w_adv = 1'b1;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_READ: begin
        if (hb_valid_i) begin
          w_adv = 1'b1;
          if (r_beat != 2'd0) w_next = S_DONE;
        end else if (w_tmo_hit) begin
          w_timeout = 1'b1;
          w_next    = S_GAP;
        end
      end
      S_DONE:  w_next = S_GAP;
      S_GAP:   if (r_gap <= c_gap_one) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_adr       <= '0;
      r_reg_space <= 1'b0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_wrq       <= 1'b0;
      r_rrq       <= 1'b0;
      r_live      <= 1'b0;
      r_err       <= 1'b0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_gap       <= '0;
      r_rbeat0    <= '0;
      r_rbeat1    <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_timeout & r_live & wb_cyc_i;
      if (w_accept) begin
        r_adr       <= w_req_adr;
        r_reg_space <= wb_adr_i[REG_SPACE_BIT];
        r_wdata     <= wb_dat_i;
        r_sel       <= wb_sel_i;
        r_wrq       <= wb_we_i;
        r_rrq       <= ~wb_we_i;
        r_live      <= 1'b1;
        r_beat      <= '0;
        r_tmo       <= '0;
      end
      if (w_busy) begin
        if (w_adv) begin
          r_beat <= r_beat + 2'd1;
          r_tmo  <= '0;
        end else begin
          r_tmo <= r_tmo + c_tmo_one;
        end
        // An abandoned cycle still finishes on HyperBus but must not be acked.
        if (!wb_cyc_i) r_live <= 1'b0;
      end
      if (w_adv && (r_state == S_READ)) begin
        if (r_beat == 2'd0) r_rbeat0 <= hb_dat_i;
        else                r_rbeat1 <= hb_dat_i;
      end
      if (w_timeout || (w_busy && (w_next == S_DONE))) begin
        r_wrq <= 1'b0;
        r_rrq <= 1'b0;
      end
      if (w_timeout || (r_state == S_DONE)) r_gap <= c_gap_load;
      else if ((r_state == S_GAP) && (r_gap != '0)) r_gap <= r_gap - c_gap_one;
    end
  end

  assign hb_adr_o       = r_adr;
  assign hb_reg_space_o = r_reg_space;
  assign hb_wrq_o       = r_wrq;
  assign hb_rrq_o       = r_rrq;
  assign hb_dat_o       = r_wrq ? ((r_beat == 2'd0) ? w_wbeat0 : w_wbeat1) : '0;
  assign hb_mask_o      = r_wrq ? ((r_beat == 2'd0) ? w_mask0 : w_mask1) : '0;
  assign wb_dat_o       = w_rdata;
  assign wb_ack_o       = (r_state == S_DONE) & r_live & wb_cyc_i & wb_stb_i;
  assign wb_err_o       = r_err & wb_cyc_i & wb_stb_i;

endmodule
`default_nettype wire
